fp32_div_seq: RTL

//  Iterative IEEE-754 single-precision divider, out = in1 / in2; inverse companion of the combinational MUL_v2.
//  One quotient bit per clock (restoring division), valid/ready on both sides, one operation in flight.

---
 rtl/fp32_div_seq_pkg.sv | 45 ++++
 rtl/fp32_div_seq_if.sv | 28 ++
 rtl/fp32_div_seq_classify.sv | 36 +++
 rtl/fp32_div_seq.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fp32_div_seq_pkg.sv
// Shared constants, FSM state encoding and operand class type for the FP32 divider.
// Latency: none (declarations only).
// Backpressure: not applicable.
package fp32_div_seq_pkg;

  localparam int FP_EXP_W  = 8;
  localparam int FP_MAN_W  = 23;
  localparam int FP_QBITS  = FP_MAN_W + 3;
  localparam int FP_DATA_W = 1 + FP_EXP_W + FP_MAN_W;
  localparam int FP_FLAG_W = 5;
  localparam int BIAS      = 127;

  localparam logic [FP_DATA_W-1:0] QNAN = 32'h7FC0_0000;
  localparam logic [FP_DATA_W-1:0] PINF = 32'h7F80_0000;

  // Bit positions inside the {NV, DZ, OF, UF, NX} flag vector
  localparam int FLAG_NV = 4;
  localparam int FLAG_DZ = 3;
  localparam int FLAG_OF = 2;
  localparam int FLAG_UF = 1;
  localparam int FLAG_NX = 0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DIV,
    ST_ROUND,
    ST_DONE
  } state_t;

  typedef struct packed {
    logic is_zero;
    logic is_inf;
    logic is_nan;
  } fp_class_t;

  // Signed infinity / signed zero encodings used by special and range-limit results
  function automatic logic [FP_DATA_W-1:0] signed_inf(input logic s);
    return {s, PINF[FP_DATA_W-2:0]};
  endfunction

  function automatic logic [FP_DATA_W-1:0] signed_zero(input logic s);
    return {s, {(FP_DATA_W-1){1'b0}}};
  endfunction

endpackage

// File: rtl/fp32_div_seq_if.sv
// Operand/result handshake bundle for the FP32 divider.
// Latency: none (wires only).
// Backpressure: in_ready throttles the producer, out_ready throttles the divider.
interface fp32_div_seq_if;
  import fp32_div_seq_pkg::*;

  logic                 in_valid;
  logic                 in_ready;
  logic [FP_DATA_W-1:0] in1;
  logic [FP_DATA_W-1:0] in2;
  logic                 out_valid;
  logic                 out_ready;
  logic [FP_DATA_W-1:0] out;
  logic [FP_FLAG_W-1:0] flags;

  // Producer/consumer side (drives operands, accepts results)
  modport master (
    output in_valid, in1, in2, out_ready,
    input  in_ready, out_valid, out, flags
  );

  // Divider side
  modport slave (
    input  in_valid, in1, in2, out_ready,
    output in_ready, out_valid, out, flags
  );

endinterface

// File: rtl/fp32_div_seq_classify.sv
// Unpacks one FP32 operand into sign/exponent/mantissa-with-hidden-bit and its class.
// Latency: combinational.
// Backpressure: not applicable; subnormals are flushed to signed zero here.
module fp32_classify
  import fp32_div_seq_pkg::*;
#(
  parameter int EXP_W = FP_EXP_W,
  parameter int MAN_W = FP_MAN_W
) (
  input  logic [EXP_W+MAN_W:0] x,
  output logic                 sign,
  output logic [EXP_W-1:0]     expn,
  output logic [MAN_W:0]       mant,
  output fp_class_t            cls
);

  logic [MAN_W-1:0] frac;

  assign frac = x[MAN_W-1:0];

  // Decode fields; a zero exponent (zero or subnormal) becomes a clean signed zero
  always_comb begin
    sign = x[EXP_W+MAN_W];
    expn = x[EXP_W+MAN_W-1:MAN_W];
    mant = {1'b1, frac};
    cls  = '0;
    if (expn == '0) begin
      cls.is_zero = 1'b1;
      mant        = '0;
    end else if (expn == '1) begin
      cls.is_inf = (frac == '0);
      cls.is_nan = (frac != '0);
    end
  end

endmodule

// File: rtl/fp32_div_seq.sv
// Iterative FP32 divider (restoring, one quotient bit per clock), out = in1 / in2, RNE rounding.
// Latency: 27 clocks accept-to-out_valid for normal operands, 1 for special operands.
// Backpressure: one op in flight; in_ready only in IDLE, result held until out_ready.
module fp32_div_seq
  import fp32_div_seq_pkg::*;
#(
  parameter int EXP_W = FP_EXP_W,
  parameter int MAN_W = FP_MAN_W,
  parameter int QBITS = MAN_W + 3
) (
  input logic           clk,
  input logic           rst,
  fp32_div_seq_if.slave bus
);

  localparam int W     = 1 + EXP_W + MAN_W;
  localparam int REM_W = MAN_W + 2;
  localparam int E_W   = EXP_W + 2;
  localparam int CNT_W = $clog2(QBITS);

  localparam logic signed [E_W-1:0] E_ONE  = E_W'(1);
  localparam logic signed [E_W-1:0] E_ZERO = '0;
  localparam logic signed [E_W-1:0] E_BIAS = E_W'(BIAS);
  localparam logic signed [E_W-1:0] E_MAX  = E_W'((1 << EXP_W) - 1);
  localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(QBITS - 1);

  // Operand decode
  logic             a_sign, b_sign;
  logic [EXP_W-1:0] a_exp, b_exp;
  logic [MAN_W:0]   a_mant, b_mant;
  fp_class_t        a_cls, b_cls;

  fp32_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_cls_a (
    .x    (bus.in1),
    .sign (a_sign),
    .expn (a_exp),
    .mant (a_mant),
    .cls  (a_cls)
  );

  fp32_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_cls_b (
    .x    (bus.in2),
    .sign (b_sign),
    .expn (b_exp),
    .mant (b_mant),
    .cls  (b_cls)
  );

  // State and datapath registers
  state_t                state_q, state_nxt;
  logic                  sign_q;
  logic signed [E_W-1:0] exp_q;
  logic [REM_W-1:0]      rem_q;
  logic [MAN_W:0]        div_q;
  logic [QBITS-1:0]      q_q;
  logic [CNT_W-1:0]      cnt_q;
  logic [W-1:0]          out_q;
  logic [FP_FLAG_W-1:0]  flags_q;
  logic                  out_valid_q;

  // FSM strobes
  logic accept, div_step, round_load, retire;

  // Special-case decode
  logic                 res_sign;
  logic                 spec_hit;
  logic [W-1:0]         spec_res;
  logic [FP_FLAG_W-1:0] spec_flags;
  logic signed [E_W-1:0] exp_init;

  // Divide step
  logic             rem_ge;
  logic [REM_W-1:0] rem_sub, rem_step;

  // Rounding
  logic [MAN_W:0]        rnd_mant, fin_mant;
  logic [MAN_W+1:0]      mant_sum;
  logic                  rnd_g, rnd_s, rnd_inc;
  logic signed [E_W-1:0] rnd_exp, fin_exp;
  logic [W-1:0]          rnd_res;
  logic [FP_FLAG_W-1:0]  rnd_flags;

  assign res_sign = a_sign ^ b_sign;
  assign exp_init = $signed({2'b00, a_exp}) - $signed({2'b00, b_exp}) + E_BIAS;

  assign bus.in_ready  = (state_q == ST_IDLE) && !rst;
  assign bus.out_valid = out_valid_q;
  assign bus.out       = out_q;
  assign bus.flags     = flags_q;

  // Resolve operand combinations that bypass the iterative divider
  always_comb begin
    spec_hit   = 1'b1;
    spec_res   = '0;
    spec_flags = '0;
    if (a_cls.is_nan || b_cls.is_nan ||
        (a_cls.is_zero && b_cls.is_zero) || (a_cls.is_inf && b_cls.is_inf)) begin
      spec_res            = QNAN;
      spec_flags[FLAG_NV] = 1'b1;
    end else if (a_cls.is_inf) begin
      // inf over anything finite, including zero, is an exact infinity
      spec_res = signed_inf(res_sign);
    end else if (b_cls.is_zero) begin
      spec_res            = signed_inf(res_sign);
      spec_flags[FLAG_DZ] = 1'b1;
    end else if (b_cls.is_inf || a_cls.is_zero) begin
      spec_res = signed_zero(res_sign);
    end else begin
      spec_hit = 1'b0;
    end
  end

  // Restoring step: remainder stays below twice the divisor, so REM_W bits never overflow
  always_comb begin
    rem_ge   = rem_q >= {1'b0, div_q};
    rem_sub  = rem_ge ? (rem_q - {1'b0, div_q}) : rem_q;
    rem_step = {rem_sub[REM_W-2:0], 1'b0};
  end

  // Normalise the quotient, round to nearest even and apply range limits
  always_comb begin
    if (q_q[QBITS-1]) begin
      rnd_mant = q_q[QBITS-1:2];
      rnd_g    = q_q[1];
      rnd_s    = q_q[0] | (|rem_q);
      rnd_exp  = exp_q;
    end else begin
      rnd_mant = q_q[QBITS-2:1];
      rnd_g    = q_q[0];
      rnd_s    = |rem_q;
      rnd_exp  = exp_q - E_ONE;
    end
    rnd_inc  = rnd_g & (rnd_s | rnd_mant[0]);
    mant_sum = {1'b0, rnd_mant} + {{(MAN_W+1){1'b0}}, rnd_inc};
    if (mant_sum[MAN_W+1]) begin
      fin_mant = mant_sum[MAN_W+1:1];
      fin_exp  = rnd_exp + E_ONE;
    end else begin
      fin_mant = mant_sum[MAN_W:0];
      fin_exp  = rnd_exp;
    end
    rnd_flags = '0;
    if (fin_exp >= E_MAX) begin
      rnd_res            = signed_inf(sign_q);
      rnd_flags[FLAG_OF] = 1'b1;
      rnd_flags[FLAG_NX] = 1'b1;
    end else if (fin_exp <= E_ZERO) begin
      rnd_res            = signed_zero(sign_q);
      rnd_flags[FLAG_UF] = 1'b1;
      rnd_flags[FLAG_NX] = 1'b1;
    end else begin
      rnd_res            = {sign_q, fin_exp[EXP_W-1:0], fin_mant[MAN_W-1:0]};
      rnd_flags[FLAG_NX] = rnd_g | rnd_s;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_nxt;
    end
  end

  // Next-state and per-state strobes
  always_comb begin
    state_nxt  = state_q;
    accept     = 1'b0;
    div_step   = 1'b0;
    round_load = 1'b0;
    retire     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.in_valid && bus.in_ready) begin
          accept    = 1'b1;
          state_nxt = spec_hit ? ST_DONE : ST_DIV;
        end
      end
      ST_DIV: begin
        div_step = 1'b1;
        if (cnt_q == CNT_LAST) begin
          state_nxt = ST_ROUND;
        end
      end
      ST_ROUND: begin
        round_load = 1'b1;
        state_nxt  = ST_DONE;
      end
      ST_DONE: begin
        if (bus.out_ready) begin
          retire    = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Datapath: operand capture, quotient iteration and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      sign_q      <= 1'b0;
      exp_q       <= '0;
      rem_q       <= '0;
      div_q       <= '0;
      q_q         <= '0;
      cnt_q       <= '0;
      out_q       <= '0;
      flags_q     <= '0;
      out_valid_q <= 1'b0;
    end else begin
      if (accept) begin
        sign_q <= res_sign;
        exp_q  <= exp_init;
        rem_q  <= {1'b0, a_mant};
        div_q  <= b_mant;
        q_q    <= '0;
        cnt_q  <= '0;
        if (spec_hit) begin
          out_q       <= spec_res;
          flags_q     <= spec_flags;
          out_valid_q <= 1'b1;
        end
      end
      if (div_step) begin
        rem_q <= rem_step;
        q_q   <= {q_q[QBITS-2:0], rem_ge};
        cnt_q <= cnt_q + 1'b1;
      end
      if (round_load) begin
        out_q       <= rnd_res;
        flags_q     <= rnd_flags;
        out_valid_q <= 1'b1;
      end
      if (retire) begin
        out_valid_q <= 1'b0;
      end
    end
  end

endmodule
